// File: rtl/fb_line_pacer_if.sv
// fb_line_pacer_if: event/status bundle between the line pacer and its surroundings.
// Ports: enable, core_frame_start, core_line_done, hdmi_frame_start, hdmi_line_req (to pacer);
// pause_core, locked, occupancy, overrun, underrun, hold_timeout (from pacer);
// stat_underruns, stat_overruns, stat_throttle_cycles only when FB_PACER_STATS_EN is defined.
interface fb_line_pacer_if #(parameter int DEPTH = 16);
  logic enable;
  logic core_frame_start;
  logic core_line_done;
  logic hdmi_frame_start;
  logic hdmi_line_req;
  logic pause_core;
  logic locked;
  logic [$clog2(DEPTH):0] occupancy;
  logic overrun;
  logic underrun;
  logic hold_timeout;
`ifdef FB_PACER_STATS_EN
  logic [15:0] stat_underruns;
  logic [15:0] stat_overruns;
  logic [15:0] stat_throttle_cycles;
  modport slave (input enable, core_frame_start, core_line_done, hdmi_frame_start, hdmi_line_req,
                 output pause_core, locked, occupancy, overrun, underrun, hold_timeout,
                 stat_underruns, stat_overruns, stat_throttle_cycles);
  modport master (output enable, core_frame_start, core_line_done, hdmi_frame_start, hdmi_line_req,
                  input pause_core, locked, occupancy, overrun, underrun, hold_timeout,
                  stat_underruns, stat_overruns, stat_throttle_cycles);
`else
  modport slave (input enable, core_frame_start, core_line_done, hdmi_frame_start, hdmi_line_req,
                 output pause_core, locked, occupancy, overrun, underrun, hold_timeout);
  modport master (output enable, core_frame_start, core_line_done, hdmi_frame_start, hdmi_line_req,
                  input pause_core, locked, occupancy, overrun, underrun, hold_timeout);
`endif
endinterface

// File: rtl/fb_line_pacer.sv
// fb_line_pacer: phase-locks and throttles the core against the HDMI line ring.
// Ports: clk, reset (async active-high), bus (fb_line_pacer_if.slave: event inputs, pause/lock/occupancy/pulse outputs).
// Optional FB_PACER_STATS_EN adds 16-bit saturating underrun/overrun/throttle-cycle counters.
module fb_line_pacer #(
  parameter int DEPTH        = 16,
  parameter int HIGH_WATER   = 12,
  parameter int LOW_WATER    = 8,
  parameter int PRIME_LINES  = 1,
  parameter int HOLD_TIMEOUT = 2000000
) (
  input logic clk,
  input logic reset,
  fb_line_pacer_if.slave bus
);
  localparam int OW = $clog2(DEPTH) + 1;
  localparam int TW = $clog2(HOLD_TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, ARM, HOLD, RUN} state_t;
  state_t state, state_n;
  logic [OW-1:0] occ, occ_d, occ_n;
  logic [TW-1:0] timer, timer_n;
  logic pause, pause_n, locked, inc, dec, full, empty, ovf, unf, to;
  logic overrun, underrun, hold_timeout;
  always_comb begin
    inc = bus.core_line_done & ~bus.hdmi_line_req;
    dec = bus.hdmi_line_req & ~bus.core_line_done;
    full = occ == OW'(DEPTH);
    empty = occ == '0;
    occ_d = (inc & ~full) ? occ + 1'b1 : (dec & ~empty) ? occ - 1'b1 : occ;
    ovf = bus.enable & (state != IDLE) & inc & full;
    unf = bus.enable & (state != IDLE) & dec & empty;
    to = bus.enable & (state == HOLD) & ~bus.hdmi_frame_start & (timer == TW'(HOLD_TIMEOUT - 1));
    state_n = state;
    occ_n = occ_d;
    pause_n = pause;
    if (!bus.enable) begin
      state_n = IDLE;
      occ_n = '0;
      pause_n = 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          occ_n = bus.core_frame_start ? '0 : occ;
          pause_n = 1'b0;
          state_n = bus.core_frame_start ? ARM : IDLE;
        end
        ARM: begin
          state_n = (occ_d >= OW'(PRIME_LINES)) ? HOLD : ARM;
          pause_n = occ_d >= OW'(PRIME_LINES);
        end
        HOLD: begin
          state_n = bus.hdmi_frame_start ? RUN : to ? IDLE : HOLD;
          pause_n = ~bus.hdmi_frame_start & ~to;
        end
        RUN: begin
          // between the watermarks the previous pause decision is kept (hysteresis)
          state_n = unf ? IDLE : RUN;
          pause_n = unf ? 1'b0 : (occ_d >= OW'(HIGH_WATER)) ? 1'b1 : (occ_d <= OW'(LOW_WATER)) ? 1'b0 : pause;
        end
      endcase
    end
    timer_n = (state == HOLD && state_n == HOLD) ? timer + 1'b1 : '0;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      occ <= '0;
      timer <= '0;
      pause <= 1'b0;
      locked <= 1'b0;
      overrun <= 1'b0;
      underrun <= 1'b0;
      hold_timeout <= 1'b0;
    end else begin
      state <= state_n;
      occ <= occ_n;
      timer <= timer_n;
      pause <= pause_n;
      locked <= state_n == RUN;
      overrun <= ovf;
      underrun <= unf;
      hold_timeout <= to;
    end
  end
  assign bus.pause_core = pause;
  assign bus.locked = locked;
  assign bus.occupancy = occ;
  assign bus.overrun = overrun;
  assign bus.underrun = underrun;
  assign bus.hold_timeout = hold_timeout;
`ifdef FB_PACER_STATS_EN
  logic [15:0] st_u, st_o, st_t;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_u <= '0;
      st_o <= '0;
      st_t <= '0;
    end else begin
      st_u <= st_u + 16'(unf & ~&st_u);
      st_o <= st_o + 16'(ovf & ~&st_o);
      st_t <= st_t + 16'((state == RUN) & pause & ~&st_t);
    end
  end
  assign bus.stat_underruns = st_u;
  assign bus.stat_overruns = st_o;
  assign bus.stat_throttle_cycles = st_t;
`endif
endmodule
